multicycle_controller: RTL and testbench

//  Moore FSM sequencing the shared-memory multicycle MIPS datapath: one instruction per 3-5 cycles.

---
 rtl/mips_defs.sv | 74 +++++++
 rtl/aludec.sv | 29 ++
 rtl/multicycle_controller.sv | 102 ++++++++++
 tb/tb_multicycle_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcodes, ALU op codes and the per-state control word.
package mips_defs;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [3:0] LAST_STATE = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       bne;
  } ctrl_t;

  // Moore control word for a given state; unused encodings yield all zeros.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_BNEEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.bne = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps aluop and R-type funct onto the 3-bit ALU function.
module aludec
  import mips_defs::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  // Fixed add/sub for address and branch work, funct decode for R-type.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_ADD: alucontrol = 3'b010;
      ALUOP_SUB: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'bxxx;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory multicycle MIPS datapath.
module multicycle_controller
  import mips_defs::*;
#(
  parameter int SUPPORT_ADDI = 1,
  parameter int SUPPORT_J    = 1,
  parameter int SUPPORT_BNE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   op_legal;
  logic   en_ok;

  // Opcode legality, honouring which optional instructions are built in.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
      OP_ADDI: op_legal = (SUPPORT_ADDI != 0);
      OP_J:    op_legal = (SUPPORT_J != 0);
      OP_BNE:  op_legal = (SUPPORT_BNE != 0);
      default: op_legal = 1'b0;
    endcase
  end

  // Next state; op only steers the DECODE and MEMADR branches.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (!op_legal)                     state_d = S_FETCH;
        else if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)           state_d = S_RTYPEEX;
        else if (op == OP_BEQ)             state_d = S_BEQEX;
        else if (op == OP_ADDI)            state_d = S_ADDIEX;
        else if (op == OP_J)               state_d = S_JEX;
        else                               state_d = S_BNEEX;
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  // State register with the control word registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Enables drop during reset and in any unused state encoding.
  assign en_ok = ~reset & (state_q <= LAST_STATE);

  assign iord       = ctrl_q.iord;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsrc      = ctrl_q.pcsrc;
  assign irwrite    = en_ok & ctrl_q.irwrite;
  assign memwrite   = en_ok & ctrl_q.memwrite;
  assign regwrite   = en_ok & ctrl_q.regwrite;
  assign pcen       = en_ok & (ctrl_q.pcwrite | (ctrl_q.branch & zero) | (ctrl_q.bne & ~zero));
  assign illegal_op = ~reset & (state_q == S_DECODE) & ~op_legal;
  assign state_o    = state_q;

  aludec u_aludec (
    .funct      (funct),
    .aluop      (ctrl_q.aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level reference model versus the controller.
module tb_multicycle_controller;

  localparam bit MODEL_ADDI = 1'b1;
  localparam bit MODEL_J    = 1'b1;
  localparam bit MODEL_BNE  = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  logic       illegal_op;

  int total = 0;
  int bad   = 0;
  int exp_path[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .state_o(state_o),
    .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    case (o)
      6'b000000, 6'b100011, 6'b101011, 6'b000100: return 1'b1;
      6'b001000: return MODEL_ADDI;
      6'b000010: return MODEL_J;
      6'b000101: return MODEL_BNE;
      default:   return 1'b0;
    endcase
  endfunction

  // Sequence of states an instruction visits, FETCH first.
  function automatic void build_path(input logic [5:0] o);
    exp_path = '{0, 1};
    if (is_legal(o)) begin
      case (o)
        6'b100011: exp_path = '{0, 1, 2, 3, 4};
        6'b101011: exp_path = '{0, 1, 2, 5};
        6'b000000: exp_path = '{0, 1, 6, 7};
        6'b000100: exp_path = '{0, 1, 8};
        6'b001000: exp_path = '{0, 1, 9, 10};
        6'b000010: exp_path = '{0, 1, 11};
        6'b000101: exp_path = '{0, 1, 12};
        default:   exp_path = '{0, 1};
      endcase
    end
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'bxxx;
    endcase
  endfunction

  task automatic check_cycle(input int st, input bit ill);
    logic [2:0] alu_e;
    logic [1:0] srcb_e, pcsrc_e;
    alu_e   = (st == 8 || st == 12) ? 3'b110 : (st == 6) ? funct_alu(funct) : 3'b010;
    srcb_e  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 9) ? 2'b10 : 2'b00;
    pcsrc_e = (st == 8 || st == 12) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
    chk("state", state_o, 4'(st));
    chk("irwrite", {3'b0, irwrite}, {3'b0, st == 0});
    chk("memwrite", {3'b0, memwrite}, {3'b0, st == 5});
    chk("regwrite", {3'b0, regwrite}, {3'b0, st == 4 || st == 7 || st == 10});
    chk("memtoreg", {3'b0, memtoreg}, {3'b0, st == 4});
    chk("regdst", {3'b0, regdst}, {3'b0, st == 7});
    chk("iord", {3'b0, iord}, {3'b0, st == 3 || st == 5});
    chk("alusrca", {3'b0, alusrca}, {3'b0, st == 2 || st == 6 || st == 8 || st == 9 || st == 12});
    chk("alusrcb", {2'b0, alusrcb}, {2'b0, srcb_e});
    chk("pcsrc", {2'b0, pcsrc}, {2'b0, pcsrc_e});
    chk("pcen", {3'b0, pcen},
        {3'b0, st == 0 || st == 11 || (st == 8 && zero) || (st == 12 && !zero)});
    chk("illegal_op", {3'b0, illegal_op}, {3'b0, ill});
    chk("alucontrol", {1'b0, alucontrol}, {1'b0, alu_e});
  endtask

  // zmode: 0 random zero, 1 force 0, 2 force 1. Op is garbage during FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
    bit ill;
    build_path(o);
    ill = !is_legal(o);
    for (int i = 0; i < exp_path.size(); i++) begin
      op    = (i == 0) ? 6'($urandom) : o;
      funct = f;
      zero  = (zmode == 0) ? 1'($urandom) : (zmode == 2);
      #2;
      check_cycle(exp_path[i], ill && i == 1);
      $display("cycle op=%b funct=%b zero=%0d state=%0d", o, f, zero, state_o);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] functs [5];
    logic [5:0] rop, rf;
    int k;
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    op = 6'b0; funct = 6'b0; zero = 1'b0;

    // Reset for two cycles; enables held low while reset is high.
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", state_o, 4'd0);
    chk("rst_irwrite", {3'b0, irwrite}, 4'd0);
    chk("rst_pcen", {3'b0, pcen}, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_state", state_o, 4'd0);
    chk("post_rst_irwrite", {3'b0, irwrite}, 4'd1);
    chk("post_rst_pcen", {3'b0, pcen}, 4'd1);
    chk("post_rst_alusrcb", {2'b0, alusrcb}, 4'd1);
    $display("reset released state=%0d", state_o);

    // Directed instructions.
    run_instr(6'b100011, 6'b000000, 0);
    run_instr(6'b000100, 6'b000000, 2);
    run_instr(6'b000100, 6'b000000, 1);
    run_instr(6'b000000, 6'b100010, 0);
    run_instr(6'b111111, 6'b000000, 0);
    run_instr(6'b000101, 6'b000000, 0);
    run_instr(6'b101011, 6'b000000, 0);

    // Reset during MEMWR aborts the store.
    op = 6'b101011;
    repeat (3) begin @(posedge clk); #1; end
    chk("sw_state", state_o, 4'd5);
    reset = 1'b1;
    #1;
    chk("abort_memwrite", {3'b0, memwrite}, 4'd0);
    $display("reset in state=%0d memwrite=%0d", state_o, memwrite);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_state", state_o, 4'd0);

    // Random instruction mix.
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 7);
      rf = functs[$urandom_range(0, 4)];
      case (k)
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000000;
        3: rop = 6'b000100;
        4: rop = 6'b001000;
        5: rop = 6'b000010;
        6: rop = 6'b000101;
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, rf, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
